sum_accum: RTL and testbench

Clocked partial-sum accumulator that sits directly upstream of the sum packetizer in the NoC datapath. It consumes 32-bit flits from the router carrying 9-bit partial sums from the PEs. It adds `NUM_PART` of them into one result, saturates the result to 9 bits, and presents it to the packetizer over a valid/ready handshake. One result is produced per `NUM_PART` accepted flits.

---
 rtl/sum_accum.sv | 106 ++++++++++
 tb/tb_sum_accum.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_accum.sv
// Purpose: accumulates NUM_PART 9-bit partial sums from NoC flits into one saturated result.
// Latency: out_valid rises on the edge that accepts the final partial (visible the next cycle).
// Backpressure: in_ready drops while a result is held; it waits for out_ready before accepting again.
// Optional feature: define SUM_DEST_CHECK_EN to discard flits whose dest field is not MY_ADDR.
module sum_accum #(
    parameter int         WIDTH    = 32,
    parameter int         DATA_W   = 9,
    parameter int         NUM_PART = 5,
    parameter logic [2:0] MY_ADDR  = 3'b100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic [7:0]        drop_cnt
);

    localparam int CNT_W = $clog2(NUM_PART);
    localparam int ACC_W = DATA_W + CNT_W;

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_PART - 1);
    localparam logic [ACC_W-1:0] SAT_MAX  = {{(ACC_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};

    logic [0:0]        r_state;
    logic [ACC_W-1:0]  r_acc;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_sum;

    logic              w_accept;
    logic              w_count;
    logic              w_last;
    logic [ACC_W-1:0]  w_payload;
    logic [ACC_W-1:0]  w_sum;
    logic [DATA_W-1:0] w_sat;
    logic              w_unused;

    // Source field and upper flit bits carry nothing this block needs.
    assign w_unused = ^{in_data[WIDTH-1:DATA_W], MY_ADDR};

    assign in_ready  = (r_state == ST_ACCUM);
    assign w_accept  = in_valid && in_ready;
    assign w_payload = {{(ACC_W-DATA_W){1'b0}}, in_data[DATA_W-1:0]};
    assign w_sum     = r_acc + w_payload;
    assign w_sat     = (w_sum > SAT_MAX) ? {DATA_W{1'b1}} : w_sum[DATA_W-1:0];
    assign w_last    = (r_cnt == CNT_LAST);

`ifdef SUM_DEST_CHECK_EN
    logic [7:0] r_drop_cnt;

    assign w_count  = (in_data[26:24] == MY_ADDR);
    assign drop_cnt = r_drop_cnt;

    // Count flits accepted but discarded for a foreign destination, saturating at 255.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= 8'd0;
        end else if (w_accept && !w_count && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end
`else
    assign w_count  = 1'b1;
    assign drop_cnt = 8'd0;
`endif

    // Accumulate partials in ACCUM; present and hold the saturated result in HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_ACCUM;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
        end else if (r_state == ST_ACCUM) begin
            if (w_accept && w_count) begin
                if (w_last) begin
                    r_out_sum   <= w_sat;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_HOLD;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end else begin
            if (out_ready) begin
                r_out_valid <= 1'b0;
                r_acc       <= '0;
                r_cnt       <= '0;
                r_state     <= ST_ACCUM;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;

endmodule

// File: tb/tb_sum_accum.sv
// Bench for sum_accum: directed flit sequences, a queue-based model of the result stream
// checked every cycle, plus hand-computed literal expectations for each scenario.
module tb_sum_accum;

    localparam int NP = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [8:0]  out_sum;
    logic [7:0]  drop_cnt;

    sum_accum dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic bit dest_ok(input logic [31:0] d);
`ifdef SUM_DEST_CHECK_EN
        return d[26:24] == 3'b100;
`else
        return 1'b1;
`endif
    endfunction

    // Model: collected partials, pending result, drop count.
    int m_parts[$];
    bit m_hold = 1'b0;
    int m_sum  = 0;
    int m_drop = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_parts.delete();
            m_hold = 1'b0;
            m_sum  = 0;
            m_drop = 0;
        end else if (m_hold) begin
            if (out_ready) m_hold = 1'b0;
        end else if (in_valid) begin
            if (dest_ok(in_data)) begin
                m_parts.push_back(int'(in_data[8:0]));
                if (m_parts.size() == NP) begin
                    int s;
                    s = m_parts.sum();
                    m_sum  = (s > 511) ? 511 : s;
                    m_hold = 1'b1;
                    m_parts.delete();
                end
            end else if (m_drop < 255) begin
                m_drop++;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", int'(in_ready), int'(!m_hold));
            chk("out_valid", int'(out_valid), int'(m_hold));
            if (m_hold) chk("out_sum", int'(out_sum), m_sum);
            chk("drop_cnt", int'(drop_cnt), m_drop);
        end
    end

    // Stream / dest-scenario monitors.
    bit mon_en = 1'b0;
    int n_res = 0;
    int n_stall = 0;
    bit cap_en = 1'b0;
    bit cap_done = 1'b0;
    int first_res = -1;

    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid && out_ready && out_sum == 9'd5) n_res++;
            if (!in_ready) n_stall++;
        end
        if (cap_en && !cap_done && out_valid) begin
            first_res = int'(out_sum);
            cap_done  = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input int v, input logic [2:0] dest = 3'b100);
        bit ok;
        bit r;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = {2'b00, 3'b000, dest, 15'd0, v[8:0]};
        for (int i = 0; i < 50 && !ok; i++) begin
            r = in_ready;
            tick();
            if (r) ok = 1'b1;
        end
        in_valid = 1'b0;
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic wait_result(input string nm, input int exp);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            if (out_valid) begin
                chk(nm, int'(out_sum), exp);
                got = 1'b1;
            end else begin
                tick();
            end
        end
        if (!got) chk({nm, "_timeout"}, 0, 1);
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        // Reset values
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_sum", int'(out_sum), 0);
        chk("rst_drop_cnt", int'(drop_cnt), 0);
        chk("rst_in_ready", int'(in_ready), 1);

        // Basic sum with one-cycle latency and return of in_ready
        out_ready = 1'b1;
        send(10); send(20); send(30); send(40); send(50);
        chk("basic_lat_valid", int'(out_valid), 1);
        chk("basic_sum", int'(out_sum), 150);
        chk("basic_hold_rdy", int'(in_ready), 0);
        tick();
        chk("basic_rdy_back", int'(in_ready), 1);
        chk("basic_valid_drop", int'(out_valid), 0);

        // Saturation and its boundary
        for (int i = 0; i < 5; i++) send(200);
        wait_result("sat_1000", 511);
        tick();
        send(100); send(100); send(100); send(100); send(111);
        wait_result("sat_exact_511", 511);
        tick();
        send(100); send(100); send(100); send(100); send(110);
        wait_result("no_sat_510", 510);
        tick();

        // Backpressure: result held 4 cycles with a flit waiting
        out_ready = 1'b0;
        send(10); send(20); send(30); send(40); send(50);
        in_valid = 1'b1;
        in_data  = {2'b00, 3'b000, 3'b100, 15'd0, 9'd7};
        for (int i = 0; i < 4; i++) begin
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_out_sum", int'(out_sum), 150);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("bp_hs_valid", int'(out_valid), 0);
        chk("bp_hs_rdy", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        send(1); send(1); send(1); send(1);
        wait_result("bp_next_sum", 11);
        tick();

        // Reset mid-accumulation
        send(7); send(7); send(7);
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", int'(out_valid), 0);
        chk("rst_mid_rdy", int'(in_ready), 1);
        #1;
        rst = 1'b0;
        tick();
        send(1); send(2); send(3); send(4); send(5);
        wait_result("rst_after_sum", 15);
        tick();

        // Reset while a result is held
        out_ready = 1'b0;
        send(1); send(2); send(3); send(4); send(5);
        chk("rst_hold_pre_valid", int'(out_valid), 1);
        rst = 1'b1;
        #1;
        chk("rst_hold_valid", int'(out_valid), 0);
        chk("rst_hold_sum", int'(out_sum), 0);
        chk("rst_hold_rdy", int'(in_ready), 1);
        #1;
        rst = 1'b0;
        tick();
        out_ready = 1'b1;

        // Back-to-back stream of ten ones
        mon_en = 1'b1;
        for (int i = 0; i < 10; i++) send(1);
        tick();
        mon_en = 1'b0;
        chk("stream_results", n_res, 2);
        chk("stream_stalls", n_stall, 2);

        // Destination filtering
        cap_en = 1'b1;
        send(10); send(20); send(30); send(40);
        send(99, 3'b001);
        send(50);
        send(99, 3'b001);
        tick();
        tick();
        cap_en = 1'b0;
`ifdef SUM_DEST_CHECK_EN
        chk("dest_first_res", first_res, 150);
        chk("dest_drop_cnt", int'(drop_cnt), 2);
`else
        chk("dest_first_res", first_res, 199);
        chk("dest_drop_cnt", int'(drop_cnt), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
